vid_pattern_gen: RTL
====================

// Module: vid_pattern_gen
// PURPOSE
//  Synthesizable video test-pattern source. Emits ROWS x COLS frames, one pixel per beat, on a
//  valid/ready stream with sop/eop framing. Drives the input of the PGM frame-capture sink.
//  Used for bring-up and regression of the downstream video pipeline under backpressure.
// PARAMETERS
//  BITS       8    pixel width
//  ROWS       240  lines per frame (>=1)
//  COLS       320  pixels per line (>=1)
//  GAP_CYCLES 16   idle cycles inserted after each frame (0 allowed)
//  CHECK_LOG2 4    log2 of checkerboard square size in pixels
// PORTS
//  clk          in   1     clock
//  arst_n       in   1     async active-low reset
//  enable       in   1     allow new frames to start
//  pattern_sel  in   3     pattern selection, sampled at frame start only
//  const_val    in   BITS  pixel value for the CONST pattern, sampled at frame start
//  data         out  BITS  pixel
//  sop          out  1     high on the first pixel of a frame (row 0, col 0)
//  eop          out  1     high on the last pixel of a frame (row ROWS-1, col COLS-1)
//  valid        out  1     beat present
//  ready        in   1     sink accepts; transfer = valid && ready on a rising edge
//  frame_count  out  16    completed frames, wraps at 2^16
//  busy         out  1     state != IDLE
// BEHAVIOUR
//  Reset: async and active-low. Forces data=0, sop=0, eop=0, valid=0, busy=0, frame_count=0,
//   row/col counters=0, state=IDLE. A reset mid-frame abandons the frame; the next frame starts at sop.
//  FSM IDLE->ACTIVE: on an edge with enable=1. At that edge, latch pattern_sel and const_val,
//   then register the pixel (0,0) with valid=1 and sop=1. All outputs are registered.
//  ACTIVE: data/sop/eop are held stable while valid && !ready. Each transfer loads the next pixel
//   on the same edge (raster order, col fastest), so valid stays high and throughput is 1 beat/cycle.
//  Last-pixel transfer: valid<=0, frame_count+1, ->GAP if GAP_CYCLES>0, else ->IDLE.
//  GAP: stays for exactly GAP_CYCLES cycles, then ->IDLE. IDLE always lasts >=1 cycle, so valid
//   is low for GAP_CYCLES+1 cycles between frames.
//  enable is checked only in IDLE. Deasserting it mid-frame lets the current frame complete.
//  pattern_sel/const_val changes mid-frame are ignored until the next frame start.
//  Patterns (r=row, c=col, f=frame_count at frame start; results taken mod 2^BITS):
//   0 HRAMP  c+f            1 VRAMP  r
//   2 CHECK  ((r>>CHECK_LOG2)^(c>>CHECK_LOG2))&1 ? all-ones : 0
//   3 CONST  const_val      4 DIAG   r+c          5-7 reserved -> 0
//  Counters: row is clog2(ROWS) bits wide and col is clog2(COLS) bits wide (min 1). Arithmetic is
//   done at BITS+16 width and then truncated. The ROWS=1 or COLS=1 edge cases are legal.
//  ROWS=COLS=1: a single beat carries sop=1 and eop=1 together.
// STRUCTURE
//  Package vid_pkg: pattern enum (PAT_HRAMP..PAT_DIAG), gen state enum (IDLE/ACTIVE/GAP).
//  The stream framing convention (sop/eop semantics) is shared with the capture sink.
//  Sub-module vid_pattern_pixel: combinational (pattern, r, c, f, const_val) -> pixel, so the
//   pattern set can be extended without touching the FSM.
// TESTING (ROWS=4, COLS=6, BITS=8 unless stated)
//  1 HRAMP, ready=1, enable=1 -> frame 0 has 24 beats, each row 0..5, sop on beat 0, eop on
//    beat 23; frame_count 0->1; frame 1 row 0 = 1..6.
//  2 HRAMP, ready randomly 50% -> accepted sequence identical to test 1; data/sop/eop never
//    change while valid && !ready.
//  3 CHECK, CHECK_LOG2=1 -> row0 = 0,0,255,255,0,0; row2 = 255,255,0,0,255,255.
//  4 enable drops after beat 10 -> beats 11..23 still delivered with eop; then valid=0, busy=0.
//  5 arst_n low at beat 7 -> all outputs 0 immediately; after release + enable, first beat has
//    sop=1, data=0, frame_count=0.
//  6 GAP_CYCLES=3, ready=1 -> valid low exactly 4 cycles between eop and next sop;
//    with GAP_CYCLES=0 -> valid low exactly 1 cycle.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared types for the video test-pattern source: pattern codes, generator
// states and a counter-width helper.
package vid_pkg;

    typedef enum logic [2:0] {
        PAT_HRAMP = 3'd0,
        PAT_VRAMP = 3'd1,
        PAT_CHECK = 3'd2,
        PAT_CONST = 3'd3,
        PAT_DIAG  = 3'd4
    } pat_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } gen_state_e;

    localparam int FC_W = 16;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vid_pattern_gen_if.sv
// Pixel stream with sop/eop framing; a beat transfers when valid && ready
// are both high on a rising clock edge.
interface vid_pattern_gen_if #(
    parameter int BITS = 8
);
    logic [BITS-1:0] data;
    logic            sop;
    logic            eop;
    logic            valid;
    logic            ready;

    modport master (output data, sop, eop, valid, input ready);
    modport slave  (input data, sop, eop, valid, output ready);
endinterface

// File: rtl/vid_pattern_pixel.sv
// Combinational pixel function: (pattern, row, col, frame, const) -> pixel.
// New patterns are added here without touching the frame sequencer.
module vid_pattern_pixel
    import vid_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int RW         = 1,
    parameter int CW         = 1,
    parameter int CHECK_LOG2 = 4
) (
    input  logic [2:0]      pattern,
    input  logic [RW-1:0]   row,
    input  logic [CW-1:0]   col,
    input  logic [FC_W-1:0] fnum,
    input  logic [BITS-1:0] const_val,
    output logic [BITS-1:0] pixel
);
    localparam int AW = BITS + 16;

    logic [AW-1:0] r_w;
    logic [AW-1:0] c_w;
    logic [AW-1:0] f_w;

    always_comb begin
        r_w   = AW'(row);
        c_w   = AW'(col);
        f_w   = AW'(fnum);
        pixel = '0;
        case (pat_e'(pattern))
            PAT_HRAMP: pixel = BITS'(c_w + f_w);
            PAT_VRAMP: pixel = BITS'(r_w);
            PAT_CHECK: pixel = ((((r_w >> CHECK_LOG2) ^ (c_w >> CHECK_LOG2)) & AW'(1)) != '0) ? '1 : '0;
            PAT_CONST: pixel = const_val;
            PAT_DIAG:  pixel = BITS'(r_w + c_w);
            default:   pixel = '0;
        endcase
    end

endmodule

// File: rtl/vid_pattern_gen.sv
// Test-pattern frame source: emits ROWS x COLS frames in raster order on a
// registered valid/ready stream, with an idle gap between frames.
module vid_pattern_gen
    import vid_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int ROWS       = 240,
    parameter int COLS       = 320,
    parameter int GAP_CYCLES = 16,
    parameter int CHECK_LOG2 = 4
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               enable,
    input  logic [2:0]         pattern_sel,
    input  logic [BITS-1:0]    const_val,
    vid_pattern_gen_if.master  vs,
    output logic [FC_W-1:0]    frame_count,
    output logic               busy
);
    localparam int RW = cnt_width(ROWS);
    localparam int CW = cnt_width(COLS);
    localparam int GW = cnt_width(GAP_CYCLES + 1);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    gen_state_e      state_reg, state_next;
    logic [RW-1:0]   row_reg, row_next;
    logic [CW-1:0]   col_reg, col_next;
    logic [GW-1:0]   gap_reg, gap_next;
    logic [2:0]      pat_reg, pat_next;
    logic [BITS-1:0] const_reg, const_next;
    logic [FC_W-1:0] fbase_reg, fbase_next;
    logic [FC_W-1:0] fcount_reg, fcount_next;
    logic [BITS-1:0] data_reg, data_next;
    logic            sop_reg, sop_next;
    logic            eop_reg, eop_next;
    logic            valid_reg, valid_next;

    logic [RW-1:0]   row_adv;
    logic [CW-1:0]   col_adv;
    logic [2:0]      pix_pat;
    logic [RW-1:0]   pix_row;
    logic [CW-1:0]   pix_col;
    logic [FC_W-1:0] pix_f;
    logic [BITS-1:0] pix_const;
    logic [BITS-1:0] pix_val;

    // In IDLE the pixel function sees the live selection inputs so pixel (0,0)
    // can be registered on the start edge; afterwards it sees the latched ones.
    always_comb begin
        col_adv = (col_reg == COL_LAST) ? '0 : col_reg + CW'(1);
        row_adv = (col_reg == COL_LAST) ? row_reg + RW'(1) : row_reg;
        if (state_reg == IDLE) begin
            pix_pat   = pattern_sel;
            pix_row   = '0;
            pix_col   = '0;
            pix_f     = fcount_reg;
            pix_const = const_val;
        end else begin
            pix_pat   = pat_reg;
            pix_row   = row_adv;
            pix_col   = col_adv;
            pix_f     = fbase_reg;
            pix_const = const_reg;
        end
    end

    vid_pattern_pixel #(
        .BITS       (BITS),
        .RW         (RW),
        .CW         (CW),
        .CHECK_LOG2 (CHECK_LOG2)
    ) u_pixel (
        .pattern   (pix_pat),
        .row       (pix_row),
        .col       (pix_col),
        .fnum      (pix_f),
        .const_val (pix_const),
        .pixel     (pix_val)
    );

    always_comb begin
        state_next  = state_reg;
        row_next    = row_reg;
        col_next    = col_reg;
        gap_next    = gap_reg;
        pat_next    = pat_reg;
        const_next  = const_reg;
        fbase_next  = fbase_reg;
        fcount_next = fcount_reg;
        data_next   = data_reg;
        sop_next    = sop_reg;
        eop_next    = eop_reg;
        valid_next  = valid_reg;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = ACTIVE;
                    pat_next   = pattern_sel;
                    const_next = const_val;
                    fbase_next = fcount_reg;
                    row_next   = '0;
                    col_next   = '0;
                    data_next  = pix_val;
                    sop_next   = 1'b1;
                    eop_next   = (ROW_LAST == '0) && (COL_LAST == '0);
                    valid_next = 1'b1;
                end
            end
            ACTIVE: begin
                if (valid_reg && vs.ready) begin
                    if (eop_reg) begin
                        valid_next  = 1'b0;
                        sop_next    = 1'b0;
                        eop_next    = 1'b0;
                        row_next    = '0;
                        col_next    = '0;
                        gap_next    = '0;
                        fcount_next = fcount_reg + FC_W'(1);
                        state_next  = (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else begin
                        row_next  = row_adv;
                        col_next  = col_adv;
                        data_next = pix_val;
                        sop_next  = 1'b0;
                        eop_next  = (row_adv == ROW_LAST) && (col_adv == COL_LAST);
                    end
                end
            end
            GAP: begin
                gap_next = gap_reg + GW'(1);
                if (gap_reg == GAP_LAST) begin
                    gap_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg  <= IDLE;
            row_reg    <= '0;
            col_reg    <= '0;
            gap_reg    <= '0;
            pat_reg    <= '0;
            const_reg  <= '0;
            fbase_reg  <= '0;
            fcount_reg <= '0;
            data_reg   <= '0;
            sop_reg    <= 1'b0;
            eop_reg    <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            row_reg    <= row_next;
            col_reg    <= col_next;
            gap_reg    <= gap_next;
            pat_reg    <= pat_next;
            const_reg  <= const_next;
            fbase_reg  <= fbase_next;
            fcount_reg <= fcount_next;
            data_reg   <= data_next;
            sop_reg    <= sop_next;
            eop_reg    <= eop_next;
            valid_reg  <= valid_next;
        end
    end

    assign vs.data     = data_reg;
    assign vs.sop      = sop_reg;
    assign vs.eop      = eop_reg;
    assign vs.valid    = valid_reg;
    assign frame_count = fcount_reg;
    assign busy        = (state_reg != IDLE);

endmodule
